prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit.sv | 107 ++++++++++
 tb/tb_prefetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue in front of a combinational program ROM.
// Define PREFETCH_WRAP_STOP_EN to halt fetching after the last ROM address.
module prefetch_unit #(
    parameter int ADDR_W = 12,
    parameter int OPC_W  = 4,
    parameter int OPR_W  = 4,
    parameter int DEPTH  = 2,
    localparam int DATA_W = OPC_W + OPR_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              valid,
    input  logic              ready,
    output logic [OPC_W-1:0]  instr,
    output logic [OPR_W-1:0]  operand,
    output logic [ADDR_W-1:0] head_pc,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_next;
    logic              fetch_ok;
    logic              fetch;
    logic              pop;
    logic              at_end;

    assign at_end = (fetch_pc == {ADDR_W{1'b1}});

`ifdef PREFETCH_WRAP_STOP_EN
    logic halt;

    // Sticky stop once the last address has been fetched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt <= 1'b0;
        end else if (load) begin
            halt <= 1'b0;
        end else if (fetch && at_end) begin
            halt <= 1'b1;
        end
    end

    assign fetch_ok = !halt;
    assign pc_next  = at_end ? fetch_pc : fetch_pc + ADDR_W'(1);
`else
    assign fetch_ok = 1'b1;
    assign pc_next  = fetch_pc + ADDR_W'(1);
    logic unused_at_end;
    assign unused_at_end = at_end;
`endif

    assign valid = (level != '0);
    assign pop   = enable && !load && valid && ready;
    assign fetch = enable && !load && fetch_ok
                   && ((level < LVL_W'(DEPTH)) || pop);

    assign rom_addr = fetch_pc;
    assign instr    = valid ? q_data[rd_ptr][DATA_W-1:OPR_W] : '0;
    assign operand  = valid ? q_data[rd_ptr][OPR_W-1:0] : '0;
    assign head_pc  = valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (load) begin
            // Redirect flushes everything queued from the old stream.
            fetch_pc <= load_addr;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            if (fetch) begin
                q_data[wr_ptr] <= rom_data;
                q_pc[wr_ptr]   <= fetch_pc;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                fetch_pc       <= pc_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fetch, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit with ROM[a] = a[7:0].
// Popped instructions are checked by a monitor against a queue of expected PCs.
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        load;
    logic [11:0] load_addr;
    logic        valid;
    logic        ready;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic [11:0] head_pc;
    logic [1:0]  level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    assign rom_data = rom_addr[7:0];

    prefetch_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .load     (load),
        .load_addr(load_addr),
        .valid    (valid),
        .ready    (ready),
        .instr    (instr),
        .operand  (operand),
        .head_pc  (head_pc),
        .level    (level)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_range(input int first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(12'(first + i));
    endtask

    // Monitor: every accepted head is compared with the next expected PC.
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset_n && enable && !load && valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc 0x%0h expected none",
                         head_pc);
            end else begin
                e = exp_q.pop_front();
                if ({head_pc, instr, operand} !== {e, e[7:4], e[3:0]}) begin
                    n_fail++;
                    $display("FAIL pop: got pc 0x%0h %0h/%0h expected 0x%0h",
                             head_pc, instr, operand, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        ready     = 1'b0;
        load      = 1'b0;
        load_addr = '0;
        step(2);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_head_pc", head_pc, 0);
        check("rst_instr", {instr, operand}, 0);

        reset_n = 1'b1;
        enable  = 1'b1;
        step(1);
        check("fill1_valid", valid, 1);
        check("fill1_head_pc", head_pc, 0);
        check("fill1_instr", {instr, operand}, 0);
        check("fill1_level", level, 1);
        step(1);
        check("fill2_level", level, 2);
        check("fill2_rom_addr", rom_addr, 2);
        step(1);
        check("full_hold_rom_addr", rom_addr, 2);
        check("full_hold_head_pc", head_pc, 0);

        push_range(0, 10);
        ready = 1'b1;
        step(10);
        check("stream_head_pc", head_pc, 10);
        check("stream_rom_addr", rom_addr, 12);

        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("frz_head_pc", head_pc, 10);
            check("frz_level", level, 2);
            check("frz_rom_addr", rom_addr, 12);
        end
        push_range(10, 6);
        enable = 1'b1;
        step(6);
        ready = 1'b0;
        check("resume_head_pc", head_pc, 16);

        step(1);
        check("full_level", level, 2);
        load      = 1'b1;
        load_addr = 12'h0A5;
        step(1);
        load = 1'b0;
        check("flush_valid", valid, 0);
        check("flush_level", level, 0);
        check("flush_rom_addr", rom_addr, 12'h0A5);
        step(1);
        check("redir_valid", valid, 1);
        check("redir_head_pc", head_pc, 12'h0A5);
        check("redir_instr", instr, 4'hA);
        check("redir_operand", operand, 4'h5);
        push_range(12'h0A5, 4);
        ready = 1'b1;
        step(4);
        ready = 1'b0;

        load      = 1'b1;
        load_addr = 12'hFFE;
        step(1);
        load = 1'b0;
`ifdef PREFETCH_WRAP_STOP_EN
        push_range(12'hFFE, 2);
`else
        push_range(12'hFFE, 2);
        push_range(0, 2);
`endif
        ready = 1'b1;
        step(5);
        ready = 1'b0;
`ifdef PREFETCH_WRAP_STOP_EN
        check("halt_valid", valid, 0);
        check("halt_rom_addr", rom_addr, 12'hFFF);
        ready = 1'b1;
        step(3);
        ready = 1'b0;
        check("halt_sticky_valid", valid, 0);
`else
        check("wrap_rom_addr", rom_addr, 12'h003);
        check("wrap_head_pc", head_pc, 12'h002);
`endif

        load      = 1'b1;
        load_addr = 12'h100;
        step(1);
        load = 1'b0;
        step(2);
        check("pre_rst_level", level, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_level", level, 0);
        check("arst_head_pc", head_pc, 0);
        check("arst_rom_addr", rom_addr, 0);
        check("arst_instr", {instr, operand}, 0);
        step(1);
        reset_n = 1'b1;
        step(1);
        check("post_rst_head_pc", head_pc, 0);
        check("post_rst_rom_addr", rom_addr, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
